// File: rtl/clock_display_scan_pkg.sv
// Shared constants and types for the four-digit mm:ss multiplexed display scanner.
//   SEG_BLANK   - all cathodes off (active-low)
//   ANODE_OFF   - all anodes off (active-low)
//   SEG_DIGITS  - {g,f,e,d,c,b,a} active-low patterns for 0..9, index = digit value
//   digit_idx_e - scan slot, slot 0 = seconds ones ... slot 3 = minutes tens
//   snapshot_t  - one coherent time value captured at the start of each frame
package clock_display_scan_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] ANODE_OFF = 4'hF;

    localparam logic [9:0][6:0] SEG_DIGITS = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef enum logic [1:0] {
        DigSecOnes = 2'd0,
        DigSecTens = 2'd1,
        DigMinOnes = 2'd2,
        DigMinTens = 2'd3
    } digit_idx_e;

    typedef struct packed {
        logic [3:0] sec_ones;
        logic [2:0] sec_tens;
        logic [3:0] min_ones;
        logic [2:0] min_tens;
        logic       colon;
    } snapshot_t;

    // Active-low one-cold anode pattern for a scan slot.
    function automatic logic [3:0] anode_for(digit_idx_e idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/clock_display_scan_if.sv
// Time-in / display-out bundle of the display scanner.
//   master: drives enable, the four BCD digits and colon_on; observes an/seg/dp
//   slave : the scanner; consumes the time value and drives the active-low display pins
interface clock_display_scan_if;

    logic       enable;
    logic [3:0] seconds_ones;
    logic [2:0] seconds_tens;
    logic [3:0] minutes_ones;
    logic [2:0] minutes_tens;
    logic       colon_on;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (
        output enable, seconds_ones, seconds_tens, minutes_ones, minutes_tens, colon_on,
        input  an, seg, dp
    );

    modport slave (
        input  enable, seconds_ones, seconds_tens, minutes_ones, minutes_tens, colon_on,
        output an, seg, dp
    );

endinterface

// File: rtl/clock_display_scan_seg7_decode.sv
// Combinational 7-segment decoder.
//   value_i : 4-bit digit value
//   seg_o   : {g,f,e,d,c,b,a} active-low; values 10..15 decode to blank
module seg7_decode
    import clock_display_scan_pkg::*;
(
    input  logic [3:0] value_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (value_i <= 4'd9) begin
            seg_o = SEG_DIGITS[value_i];
        end
    end

endmodule

// File: rtl/clock_display_scan.sv
// Time-multiplexed scanner for a 4-digit common-anode mm:ss display.
//   clk   : single clock, all state on its rising edge
//   reset : asynchronous, active-high; blanks the display and clears all state
//   bus   : slave modport - enable, BCD digits and colon_on in; an/seg/dp out (active-low)
// Each digit slot lasts REFRESH_DIV cycles. The input time is captured once per frame on
// the 3->0 index wrap so a frame never mixes two time values. Outputs are registered and
// follow the index/snapshot one cycle later.
module clock_display_scan
    import clock_display_scan_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter bit          LZ_BLANK    = 1'b1
) (
    input logic                 clk,
    input logic                 reset,
    clock_display_scan_if.slave bus
);

    localparam int unsigned     PreW    = $clog2(REFRESH_DIV);
    localparam logic [PreW-1:0] PreLast = PreW'(REFRESH_DIV - 1);

    logic [PreW-1:0] prescaler_q, prescaler_d;
    digit_idx_e      index_q, index_d;
    snapshot_t       snap_q, snap_d, snap_live;
    logic [3:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;

    logic       tick;
    logic       lead_zero;
    logic [3:0] digit_val;
    logic [6:0] digit_seg;

    assign snap_live = '{
        sec_ones: bus.seconds_ones,
        sec_tens: bus.seconds_tens,
        min_ones: bus.minutes_ones,
        min_tens: bus.minutes_tens,
        colon:    bus.colon_on
    };

    // Tick is a clock enable only; prescaler, index and snapshot all freeze while disabled.
    assign tick = bus.enable && (prescaler_q == PreLast);

    always_comb begin
        prescaler_d = prescaler_q;
        index_d     = index_q;
        snap_d      = snap_q;
        if (bus.enable) begin
            prescaler_d = tick ? '0 : prescaler_q + 1'b1;
        end
        if (tick) begin
            index_d = digit_idx_e'(index_q + 2'd1);
            if (index_q == DigMinTens) begin
                snap_d = snap_live;
            end
        end
    end

    always_comb begin
        digit_val = '0;
        unique case (index_q)
            DigSecOnes: digit_val = snap_q.sec_ones;
            DigSecTens: digit_val = {1'b0, snap_q.sec_tens};
            DigMinOnes: digit_val = snap_q.min_ones;
            DigMinTens: digit_val = {1'b0, snap_q.min_tens};
        endcase
    end

    seg7_decode u_decode (
        .value_i (digit_val),
        .seg_o   (digit_seg)
    );

    // Leading-zero blanking keeps the anode driven so every slot has the same duty.
    assign lead_zero = LZ_BLANK && (index_q == DigMinTens) && (snap_q.min_tens == 3'd0);

    always_comb begin
        an_d  = ANODE_OFF;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (bus.enable) begin
            an_d  = anode_for(index_q);
            seg_d = lead_zero ? SEG_BLANK : digit_seg;
            dp_d  = ~((index_q == DigMinOnes) && snap_q.colon);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler_q <= '0;
            index_q     <= DigSecOnes;
            snap_q      <= '0;
            an_q        <= ANODE_OFF;
            seg_q       <= SEG_BLANK;
            dp_q        <= 1'b1;
        end else begin
            prescaler_q <= prescaler_d;
            index_q     <= index_d;
            snap_q      <= snap_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;

endmodule

// File: tb/tb_clock_display_scan.sv
// Self-checking bench for clock_display_scan: two instances (LZ_BLANK=1 and 0) share the
// same stimulus and are compared each cycle against a frame/slot arithmetic model.
module tb_clock_display_scan;

    localparam int unsigned Div      = 4;
    localparam int unsigned FrameLen = 4 * Div;

    logic       clk;
    logic       reset;
    logic       en;
    logic       col;
    logic [3:0] so;
    logic [2:0] st;
    logic [3:0] mo;
    logic [2:0] mt;

    int checks;
    int passes;

    clock_display_scan_if bus_lz1 ();
    clock_display_scan_if bus_lz0 ();

    assign bus_lz1.enable       = en;
    assign bus_lz1.seconds_ones = so;
    assign bus_lz1.seconds_tens = st;
    assign bus_lz1.minutes_ones = mo;
    assign bus_lz1.minutes_tens = mt;
    assign bus_lz1.colon_on     = col;
    assign bus_lz0.enable       = en;
    assign bus_lz0.seconds_ones = so;
    assign bus_lz0.seconds_tens = st;
    assign bus_lz0.minutes_ones = mo;
    assign bus_lz0.minutes_tens = mt;
    assign bus_lz0.colon_on     = col;

    clock_display_scan #(.REFRESH_DIV(Div), .LZ_BLANK(1'b1)) dut_lz1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_lz1)
    );

    clock_display_scan #(.REFRESH_DIV(Div), .LZ_BLANK(1'b0)) dut_lz0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_lz0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pos counts enabled cycles within a frame; slot = pos / Div.
    logic [6:0] digit_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                   7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    int         pos;
    int         snap_digits [4];
    logic       snap_col;
    logic [3:0] e_an;
    logic [6:0] e_seg1;
    logic [6:0] e_seg0;
    logic       e_dp;

    function automatic logic [6:0] pattern(int v);
        return (v < 10) ? digit_tbl[v] : 7'h7F;
    endfunction

    task automatic model_clear();
        pos         = 0;
        snap_digits = '{0, 0, 0, 0};
        snap_col    = 1'b0;
        e_an        = 4'hF;
        e_seg1      = 7'h7F;
        e_seg0      = 7'h7F;
        e_dp        = 1'b1;
    endtask

    // Expected outputs after the coming edge, then advance the model state.
    task automatic model_edge();
        int slot;
        int v;
        if (reset) begin
            model_clear();
        end else if (!en) begin
            e_an   = 4'hF;
            e_seg1 = 7'h7F;
            e_seg0 = 7'h7F;
            e_dp   = 1'b1;
        end else begin
            slot       = pos / Div;
            v          = snap_digits[slot];
            e_an       = 4'hF;
            e_an[slot] = 1'b0;
            e_seg0     = pattern(v);
            e_seg1     = (slot == 3 && v == 0) ? 7'h7F : pattern(v);
            e_dp       = !(slot == 2 && snap_col);
            pos        = (pos + 1) % FrameLen;
            if (pos == 0) begin
                snap_digits = '{int'(so), int'(st), int'(mo), int'(mt)};
                snap_col    = col;
            end
        end
    endtask

    task automatic clk_step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b0; col = 1'b0;
        so = '0; st = '0; mo = '0; mt = '0;
        model_clear();
        clk_step();
        clk_step();
        if ({bus_lz1.an, bus_lz1.seg, bus_lz1.dp} !== {4'hF, 7'h7F, 1'b1})
            $display("FAIL reset_lz1 got %b/%h/%b want 1111/7f/1",
                     bus_lz1.an, bus_lz1.seg, bus_lz1.dp);
        else passes++;
        checks++;
        if ({bus_lz0.an, bus_lz0.seg, bus_lz0.dp} !== {4'hF, 7'h7F, 1'b1})
            $display("FAIL reset_lz0 got %b/%h/%b want 1111/7f/1",
                     bus_lz0.an, bus_lz0.seg, bus_lz0.dp);
        else passes++;
        checks++;
        reset = 1'b0; en = 1'b1; col = 1'b1;
        so = 4'd4; st = 3'd3; mo = 4'd2; mt = 3'd1;
        clk_step();
        if ({bus_lz1.an, bus_lz1.seg, bus_lz1.dp} !== {4'b1110, 7'h40, 1'b1})
            $display("FAIL first_clk got %b/%h/%b want 1110/40/1",
                     bus_lz1.an, bus_lz1.seg, bus_lz1.dp);
        else passes++;
        checks++;
    endtask

    task automatic test_frame();
        logic [3:0] an_tbl  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [6:0] seg_tbl [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
        int slot;
        for (int k = 2; k <= 32; k++) begin
            clk_step();
            if ({bus_lz1.an, bus_lz1.seg, bus_lz1.dp} !== {e_an, e_seg1, e_dp})
                $display("FAIL frame_model k=%0d got %b/%h/%b want %b/%h/%b", k,
                         bus_lz1.an, bus_lz1.seg, bus_lz1.dp, e_an, e_seg1, e_dp);
            else passes++;
            checks++;
            if (k >= 17) begin
                slot = (k - 17) / 4;
                if ({bus_lz1.an, bus_lz1.seg, bus_lz1.dp} !==
                    {an_tbl[slot], seg_tbl[slot], (slot == 2) ? 1'b0 : 1'b1})
                    $display("FAIL frame_1234 k=%0d got %b/%h/%b want %b/%h/%b", k,
                             bus_lz1.an, bus_lz1.seg, bus_lz1.dp, an_tbl[slot],
                             seg_tbl[slot], (slot == 2) ? 1'b0 : 1'b1);
                else passes++;
                checks++;
            end
        end
    endtask

    task automatic test_lz_blank();
        so = 4'd9; st = 3'd0; mo = 4'd5; mt = 3'd0;
        for (int k = 1; k <= 32; k++) begin
            clk_step();
            if ({bus_lz0.an, bus_lz0.seg, bus_lz0.dp} !== {e_an, e_seg0, e_dp})
                $display("FAIL lz_model k=%0d got %b/%h/%b want %b/%h/%b", k,
                         bus_lz0.an, bus_lz0.seg, bus_lz0.dp, e_an, e_seg0, e_dp);
            else passes++;
            checks++;
            if (k >= 29) begin
                if ({bus_lz1.an, bus_lz1.seg} !== {4'b0111, 7'h7F})
                    $display("FAIL lz_blank1 k=%0d got %b/%h want 0111/7f", k,
                             bus_lz1.an, bus_lz1.seg);
                else passes++;
                checks++;
                if ({bus_lz0.an, bus_lz0.seg} !== {4'b0111, 7'h40})
                    $display("FAIL lz_blank0 k=%0d got %b/%h want 0111/40", k,
                             bus_lz0.an, bus_lz0.seg);
                else passes++;
                checks++;
            end
        end
    endtask

    task automatic test_carry();
        so = 4'd9; st = 3'd5; mo = 4'd0; mt = 3'd0;
        for (int k = 1; k <= 48; k++) begin
            if (k == 22) begin
                so = 4'd0; st = 3'd0; mo = 4'd1;
            end
            clk_step();
            if ({bus_lz1.an, bus_lz1.seg, bus_lz1.dp} !== {e_an, e_seg1, e_dp})
                $display("FAIL carry_model k=%0d got %b/%h/%b want %b/%h/%b", k,
                         bus_lz1.an, bus_lz1.seg, bus_lz1.dp, e_an, e_seg1, e_dp);
            else passes++;
            checks++;
            if (k >= 22 && k <= 24) begin
                if ({bus_lz1.an, bus_lz1.seg} !== {4'b1101, 7'h12})
                    $display("FAIL carry_hold k=%0d got %b/%h want 1101/12", k,
                             bus_lz1.an, bus_lz1.seg);
                else passes++;
                checks++;
            end
            if (k >= 33 && k <= 40) begin
                if (bus_lz1.seg !== 7'h40)
                    $display("FAIL carry_next k=%0d got %h want 40", k, bus_lz1.seg);
                else passes++;
                checks++;
            end
        end
    endtask

    task automatic test_pause();
        logic [3:0] resume_an [3] = '{4'b1101, 4'b1101, 4'b1011};
        for (int k = 0; k < 6; k++) clk_step();
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            clk_step();
            if ({bus_lz1.an, bus_lz1.seg, bus_lz1.dp} !== {4'hF, 7'h7F, 1'b1})
                $display("FAIL pause_blank k=%0d got %b/%h/%b want 1111/7f/1", k,
                         bus_lz1.an, bus_lz1.seg, bus_lz1.dp);
            else passes++;
            checks++;
        end
        en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            clk_step();
            if ({bus_lz1.an, bus_lz1.seg, bus_lz1.dp} !== {e_an, e_seg1, e_dp})
                $display("FAIL resume_model k=%0d got %b/%h/%b want %b/%h/%b", k,
                         bus_lz1.an, bus_lz1.seg, bus_lz1.dp, e_an, e_seg1, e_dp);
            else passes++;
            checks++;
            if (k < 3) begin
                if (bus_lz1.an !== resume_an[k])
                    $display("FAIL resume_slot k=%0d got %b want %b", k,
                             bus_lz1.an, resume_an[k]);
                else passes++;
                checks++;
            end
        end
    endtask

    task automatic test_invalid_digit();
        so = 4'd12; st = 3'd0; mo = 4'd0; mt = 3'd0; col = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            clk_step();
            if ({bus_lz0.an, bus_lz0.seg, bus_lz0.dp} !== {e_an, e_seg0, e_dp})
                $display("FAIL invalid_model k=%0d got %b/%h/%b want %b/%h/%b", k,
                         bus_lz0.an, bus_lz0.seg, bus_lz0.dp, e_an, e_seg0, e_dp);
            else passes++;
            checks++;
            if (k >= 17 && k <= 20) begin
                if ({bus_lz1.an, bus_lz1.seg} !== {4'b1110, 7'h7F})
                    $display("FAIL invalid_blank k=%0d got %b/%h want 1110/7f", k,
                             bus_lz1.an, bus_lz1.seg);
                else passes++;
                checks++;
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                so  = 4'($urandom_range(0, 15));
                st  = 3'($urandom_range(0, 7));
                mo  = 4'($urandom_range(0, 15));
                mt  = 3'($urandom_range(0, 7));
                col = 1'($urandom_range(0, 1));
            end
            en = ($urandom_range(0, 9) != 0);
            clk_step();
            if ({bus_lz1.an, bus_lz1.seg, bus_lz1.dp} !== {e_an, e_seg1, e_dp})
                $display("FAIL random_lz1 k=%0d got %b/%h/%b want %b/%h/%b", k,
                         bus_lz1.an, bus_lz1.seg, bus_lz1.dp, e_an, e_seg1, e_dp);
            else passes++;
            checks++;
            if ({bus_lz0.an, bus_lz0.seg, bus_lz0.dp} !== {e_an, e_seg0, e_dp})
                $display("FAIL random_lz0 k=%0d got %b/%h/%b want %b/%h/%b", k,
                         bus_lz0.an, bus_lz0.seg, bus_lz0.dp, e_an, e_seg0, e_dp);
            else passes++;
            checks++;
        end
    endtask

    task automatic test_async_reset();
        bit found;
        en = 1'b1; found = 1'b0;
        so = 4'd7; st = 3'd4; mo = 4'd8; mt = 3'd2; col = 1'b1;
        for (int k = 0; k < 64 && !found; k++) begin
            if (pos == 2 * Div + 1) found = 1'b1;
            else clk_step();
        end
        if (!found) $display("FAIL async_find got no index-2 slot want one within 64 clks");
        else passes++;
        checks++;
        #2;
        reset = 1'b1;
        model_clear();
        #1;
        if ({bus_lz1.an, bus_lz1.seg, bus_lz1.dp} !== {4'hF, 7'h7F, 1'b1})
            $display("FAIL async_blank got %b/%h/%b want 1111/7f/1",
                     bus_lz1.an, bus_lz1.seg, bus_lz1.dp);
        else passes++;
        checks++;
        clk_step();
        clk_step();
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            clk_step();
            if ({bus_lz1.an, bus_lz1.seg, bus_lz1.dp} !== {e_an, e_seg1, e_dp})
                $display("FAIL async_model k=%0d got %b/%h/%b want %b/%h/%b", k,
                         bus_lz1.an, bus_lz1.seg, bus_lz1.dp, e_an, e_seg1, e_dp);
            else passes++;
            checks++;
            if (k == 0) begin
                if ({bus_lz1.an, bus_lz1.seg} !== {4'b1110, 7'h40})
                    $display("FAIL async_restart got %b/%h want 1110/40",
                             bus_lz1.an, bus_lz1.seg);
                else passes++;
                checks++;
            end
        end
    endtask

    initial begin
        checks = 0;
        passes = 0;
        test_reset();
        test_frame();
        test_lz_blank();
        test_carry();
        test_pause();
        test_invalid_digit();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/clock_display_scan.md
CLOCK_DISPLAY_SCAN -- requirements
Module: clock_display_scan

Interface
REQ-001 Parameter REFRESH_DIV, default 100000: clk cycles per digit slot; legal range 2..2^20.
REQ-002 Parameter LZ_BLANK, default 1: 1 blanks minutes_tens when its value is 0.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  reset is asynchronous and active-high.
REQ-005 enable  input  1  1 runs scanning; 0 blanks the display and freezes the scan.
REQ-006 seconds_ones  input  4  BCD seconds units from the mod-60 seconds counter.
REQ-007 seconds_tens  input  3  seconds tens, 0..5.
REQ-008 minutes_ones  input  4  BCD minutes units.
REQ-009 minutes_tens  input  3  minutes tens, 0..5.
REQ-010 colon_on  input  1  1 lights the mm:ss separator.
REQ-011 an  output  4  digit anodes, active-low; an[0]=seconds_ones, an[3]=minutes_tens.
REQ-012 seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low.
REQ-013 dp  output  1  decimal point, active-low; used as the colon.

Function
REQ-014 Prescaler counts 0..REFRESH_DIV-1 while enable=1 and wraps to 0; a tick occurs in the cycle where prescaler = REFRESH_DIV-1.
REQ-015 A 2-bit digit index advances 0->1->2->3->0 on each tick and holds otherwise.
REQ-016 On the edge where the index wraps 3->0, all four input digits and colon_on are captured into a snapshot, so each frame shows one coherent time value.
REQ-017 an, seg and dp are registered and reflect the current index and snapshot exactly one clk after the index changes; at most one an bit is low.
REQ-018 Decode, active-low hex: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10; values 10..15 drive seg=7F (blank).
REQ-019 At index 3, if LZ_BLANK=1 and the snapshot minutes_tens = 0, then seg=7F and an=0111 (anode still driven, keeping duty uniform).
REQ-020 dp=0 only at index 2 with snapshot colon_on=1; otherwise dp=1.
REQ-021 When enable=0: an=1111, seg=7F and dp=1 from the next clk; prescaler, index and snapshot hold.
REQ-022 When enable returns to 1, scanning resumes from the held prescaler and index values without a reset.
REQ-023 Inputs change asynchronously to the scan (for example, the seconds carry); mid-frame input changes never appear before the next 3->0 wrap.

Reset
REQ-024 While reset=1: an=1111, seg=7F, dp=1, prescaler=0, index=0, snapshot all zero; these take effect immediately, regardless of clk.
REQ-025 On the first clk after reset releases with enable=1: an=1110, seg=40 (digit 0 of the zero snapshot).
REQ-026 Reset asserted mid-frame blanks the outputs within the same cycle; no partial frame resumes after release.

Structure
REQ-027 A shared package holds the ten segment patterns, the SEG_BLANK=7F constant and the ANODE_OFF=1111 constant.
REQ-028 One combinational sub-module, seg7_decode (4-bit value in, 7-bit active-low pattern out), is instantiated once on the muxed snapshot digit.
REQ-029 The top level contains the prescaler, index counter, snapshot registers, digit mux and output registers; there are no derived clocks, and ticks act as clock enables.

Verification (REFRESH_DIV=4 unless stated)
REQ-030 Reset, then enable=1 with inputs 12:34 and colon_on=1 -> the first frame shows zeros; from the second frame onward the bench sees an=1110/seg=19, 1101/30, 1011/24 with dp=0, then 0111/79, each held 4 clks.
REQ-031 Inputs 05:09 with LZ_BLANK=1 -> the index-3 slot shows an=0111, seg=7F; with LZ_BLANK=0 the same slot shows seg=40.
REQ-032 Seconds change 59->00 while index=1 -> the remaining slots of the current frame still show 59; the next frame shows 00.
REQ-033 enable=0 for 10 clks mid-frame, then enable=1 -> the bench sees an=1111 throughout the pause, and scanning resumes at the same index with its remaining count.
REQ-034 seconds_ones forced to 12 -> the index-0 slot shows seg=7F.
REQ-035 Reset pulsed asynchronously between clk edges at index 2 -> outputs are blank immediately; after release the scan restarts at index 0 with a zero snapshot.
